six_code_decoder: RTL

Receive-side companion to the six-state coded counter. Samples the 3-bit state code Q and carry C driven by that counter, decodes the code back to a binary index 0..5, and locks onto the sequence once enough consecutive correct steps have been seen. While locked, it counts completed cycles and flags illegal codes, skipped or repeated states, and carry mismatches. It sits at the consumer end of the counter's Q/C link.

---
 rtl/six_code_decoder_if.sv | 18 +
 rtl/six_code_decoder.sv | 91 +++++++++
 2 files changed

// File: rtl/six_code_decoder_if.sv
// six_code_decoder_if: sample/decode link between a coded-counter consumer and its driver
//   en, code_in, carry_in : sample strobe, 3-bit state code, carry (master -> slave)
//   idx, locked, wrap_cnt, err, err_cnt : decoder status (slave -> master)
interface six_code_decoder_if #(
    parameter int WRAP_W = 8,
    parameter int ERR_W  = 8
);
    logic              en;
    logic [2:0]        code_in;
    logic              carry_in;
    logic [2:0]        idx;
    logic              locked;
    logic [WRAP_W-1:0] wrap_cnt;
    logic              err;
    logic [ERR_W-1:0]  err_cnt;
    modport master (output en, code_in, carry_in, input idx, locked, wrap_cnt, err, err_cnt);
    modport slave  (input en, code_in, carry_in, output idx, locked, wrap_cnt, err, err_cnt);
endinterface

// File: rtl/six_code_decoder.sv
// six_code_decoder: decodes six-state counter codes, locks onto the sequence, counts wraps and faults
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : slave side of six_code_decoder_if (en/code_in/carry_in in, idx/locked/wrap_cnt/err/err_cnt out)
module six_code_decoder #(
    parameter int WRAP_W   = 8,
    parameter int ERR_W    = 8,
    parameter int LOCK_CNT = 2
) (
    input logic clk,
    input logic reset,
    six_code_decoder_if.slave bus
);
    typedef enum logic {HUNT, LOCKED} state_t;
    state_t            r_st;
    logic [2:0]        r_prev;
    logic [2:0]        r_match;
    logic [2:0]        r_idx;
    logic              r_locked;
    logic              r_err;
    logic [WRAP_W-1:0] r_wrap;
    logic [ERR_W-1:0]  r_err_cnt;
    logic [2:0]        w_dec;
    logic [2:0]        w_next;
    logic              w_legal;
    logic              w_cons;
    logic              w_succ;
    // Illegal codes fall through to 5 but are masked by w_legal everywhere.
    always_comb begin
        w_dec   = bus.code_in == 3'b010 ? 3'd0 :
                  bus.code_in == 3'b011 ? 3'd1 :
                  bus.code_in == 3'b111 ? 3'd2 :
                  bus.code_in == 3'b110 ? 3'd3 :
                  bus.code_in == 3'b100 ? 3'd4 : 3'd5;
        w_legal = bus.code_in != 3'b001 && bus.code_in != 3'b101;
        w_cons  = w_legal && (bus.carry_in == (w_dec == 3'd5));
        w_next  = r_prev == 3'd5 ? 3'd0 : r_prev + 3'd1;
        w_succ  = w_cons && w_dec == w_next;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_st      <= HUNT;
            r_prev    <= 3'd0;
            r_match   <= 3'd0;
            r_idx     <= 3'd0;
            r_locked  <= 1'b0;
            r_err     <= 1'b0;
            r_wrap    <= '0;
            r_err_cnt <= '0;
        end else begin
            r_err <= 1'b0;
            if (bus.en) begin
                if (w_legal)
                    r_idx <= w_dec;
                if (r_st == HUNT) begin
                    if (!w_cons)
                        r_match <= 3'd0;
                    else if (w_succ && r_match != 3'd0) begin
                        r_prev  <= w_dec;
                        r_match <= r_match + 3'd1;
                        // r_match counts samples; lock once LOCK_CNT successor steps follow the first one
                        if (r_match == 3'(LOCK_CNT)) begin
                            r_st     <= LOCKED;
                            r_locked <= 1'b1;
                        end
                    end else begin
                        r_prev  <= w_dec;
                        r_match <= 3'd1;
                    end
                end else if (w_succ) begin
                    r_prev <= w_dec;
                    if (r_prev == 3'd5)
                        r_wrap <= r_wrap + WRAP_W'(1);
                end else begin
                    r_err     <= 1'b1;
                    r_err_cnt <= &r_err_cnt ? r_err_cnt : r_err_cnt + ERR_W'(1);
                    r_st      <= HUNT;
                    r_locked  <= 1'b0;
                    r_match   <= w_cons ? 3'd1 : 3'd0;
                    if (w_cons)
                        r_prev <= w_dec;
                end
            end
        end
    end
    assign bus.idx      = r_idx;
    assign bus.locked   = r_locked;
    assign bus.wrap_cnt = r_wrap;
    assign bus.err      = r_err;
    assign bus.err_cnt  = r_err_cnt;
endmodule
